// File: rtl/pipeline_stage_controller.sv
// Sequencer for the 5-stage pipeline: merges load-use stalls, EX branch redirects,
// multi-cycle MEM accesses and HLT draining into register write enables and flush strobes.
module pipeline_stage_controller #(
  parameter int MEM_LATENCY = 2,
  parameter int DRAIN_DEPTH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic load_use_stall,
  input  logic branch_taken,
  input  logic exmem_memAccess,
  input  logic idex_halt,
  input  logic restart,
  output logic pc_we,
  output logic ifid_we,
  output logic idex_we,
  output logic exmem_we,
  output logic memwb_we,
  output logic if_flush,
  output logic id_flush,
  output logic mem_busy,
  output logic halted
);

  localparam int MW = $clog2(MEM_LATENCY) + 1;
  localparam int DW = $clog2(DRAIN_DEPTH) + 1;
  localparam logic [MW-1:0] MEM_LAST   = MW'(MEM_LATENCY - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_DEPTH - 1);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t        state_q, state_d;
  logic [MW-1:0] mem_cnt_q, mem_cnt_d;
  logic [DW-1:0] drain_cnt_q, drain_cnt_d;
  logic          mem_stall;

  // The counter clears on the release cycle, so back-to-back accesses each wait in full.
  assign mem_stall = !rst && exmem_memAccess && (mem_cnt_q < MEM_LAST) && (state_q != HALTED);
  assign mem_busy  = mem_stall;

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    mem_cnt_d   = mem_stall ? mem_cnt_q + MW'(1) : '0;
    case (state_q)
      RUN: begin
        if (!mem_stall && !branch_taken && idex_halt) state_d = DRAIN;
      end
      DRAIN: begin
        if (!mem_stall) begin
          if (drain_cnt_q == DRAIN_LAST) begin
            state_d     = HALTED;
            drain_cnt_d = '0;
          end else begin
            drain_cnt_d = drain_cnt_q + DW'(1);
          end
        end
      end
      HALTED: begin
        if (restart) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pc_we    = 1'b1;
    ifid_we  = 1'b1;
    idex_we  = 1'b1;
    exmem_we = 1'b1;
    memwb_we = 1'b1;
    if_flush = 1'b0;
    id_flush = 1'b0;
    halted   = 1'b0;
    if (rst) begin
      {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = '0;
      if_flush = 1'b1;
      id_flush = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (mem_stall) begin
            {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = '0;
          end else if (branch_taken) begin
            if_flush = 1'b1;
            id_flush = 1'b1;
          end else if (idex_halt || load_use_stall) begin
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            id_flush = 1'b1;
          end
        end
        DRAIN: begin
          pc_we    = 1'b0;
          ifid_we  = 1'b0;
          id_flush = 1'b1;
          idex_we  = !mem_stall;
          exmem_we = !mem_stall;
          memwb_we = !mem_stall;
        end
        default: begin
          {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = '0;
          halted = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      mem_cnt_q   <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_cnt_q   <= mem_cnt_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_stage_controller.sv
// Bench for pipeline_stage_controller: two instances (MEM_LATENCY 3 and 2) checked every cycle
// against a behavioural model, plus hand-computed directed expectations.
module tb_pipeline_stage_controller;

  logic clk = 1'b0;
  logic rst = 1'b1, load_use_stall = 1'b0, branch_taken = 1'b0;
  logic exmem_memAccess = 1'b0, idex_halt = 1'b0, restart = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Output order: pc, ifid, idex, exmem, memwb, if_flush, id_flush, mem_busy, halted
  logic [8:0] o3, o2;

  pipeline_stage_controller #(.MEM_LATENCY(3), .DRAIN_DEPTH(3)) u3 (
    .clk(clk), .rst(rst), .load_use_stall(load_use_stall), .branch_taken(branch_taken),
    .exmem_memAccess(exmem_memAccess), .idex_halt(idex_halt), .restart(restart),
    .pc_we(o3[8]), .ifid_we(o3[7]), .idex_we(o3[6]), .exmem_we(o3[5]), .memwb_we(o3[4]),
    .if_flush(o3[3]), .id_flush(o3[2]), .mem_busy(o3[1]), .halted(o3[0]));

  pipeline_stage_controller #(.MEM_LATENCY(2), .DRAIN_DEPTH(3)) u2 (
    .clk(clk), .rst(rst), .load_use_stall(load_use_stall), .branch_taken(branch_taken),
    .exmem_memAccess(exmem_memAccess), .idex_halt(idex_halt), .restart(restart),
    .pc_we(o2[8]), .ifid_we(o2[7]), .idex_we(o2[6]), .exmem_we(o2[5]), .memwb_we(o2[4]),
    .if_flush(o2[3]), .id_flush(o2[2]), .mem_busy(o2[1]), .halted(o2[0]));

  // Model: mode 0=running, 1=draining, 2=halted; served = wait cycles already paid by this access.
  localparam int DD = 3;
  int lat[2] = '{3, 2};
  int mode[2] = '{0, 0};
  int served[2] = '{0, 0};
  int drained[2] = '{0, 0};

  function automatic logic waiting(int l, int m, int s);
    return exmem_memAccess && (s < l - 1) && (m != 2) && !rst;
  endfunction

  function automatic logic [8:0] expect_out(int l, int m, int s);
    logic st;
    st = waiting(l, m, s);
    if (rst) return 9'b00000_11_00;
    if (m == 2) return 9'b00000_00_01;
    if (m == 1) return {2'b00, {3{!st}}, 2'b01, st, 1'b0};
    if (st) return 9'b00000_00_10;
    if (branch_taken) return 9'b11111_11_00;
    if (idex_halt || load_use_stall) return 9'b00111_01_00;
    return 9'b11111_00_00;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic st;
      st = waiting(lat[i], mode[i], served[i]);
      if (rst) begin
        mode[i] = 0; served[i] = 0; drained[i] = 0;
      end else begin
        served[i] = st ? served[i] + 1 : 0;
        if (mode[i] == 0) begin
          if (!st && !branch_taken && idex_halt) mode[i] = 1;
        end else if (mode[i] == 1) begin
          if (!st) begin
            drained[i]++;
            if (drained[i] == DD) begin mode[i] = 2; drained[i] = 0; end
          end
        end else if (restart) begin
          mode[i] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [8:0] e, a;
      e = expect_out(lat[i], mode[i], served[i]);
      a = (i == 0) ? o3 : o2;
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL model_lat%0d t=%0t actual=%b required=%b", lat[i], $time, a, e);
      end
    end
  end

  task automatic lit(input string nm, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s t=%0t actual=%b required=%b", nm, $time, act, req);
    end
  endtask

  task automatic cyc(input logic r, lu, br, mem, hlt, rs);
    @(posedge clk);
    #1;
    rst = r; load_use_stall = lu; branch_taken = br;
    exmem_memAccess = mem; idex_halt = hlt; restart = rs;
    @(negedge clk);
  endtask

  logic pat[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    // reset
    cyc(1, 0, 0, 0, 0, 0);
    lit("rst_pc_we", o3[8], 1'b0);
    lit("rst_memwb_we", o3[4], 1'b0);
    lit("rst_if_flush", o3[3], 1'b1);
    lit("rst_id_flush", o3[2], 1'b1);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    lit("rel_pc_we", o3[8], 1'b1);
    lit("rel_if_flush", o3[3], 1'b0);
    lit("rel_halted", o3[0], 1'b0);

    // memory wait, latency 3
    cyc(0, 0, 0, 1, 0, 0);
    lit("mem_c1_busy", o3[1], 1'b1);
    lit("mem_c1_pc_we", o3[8], 1'b0);
    cyc(0, 0, 0, 1, 0, 0);
    lit("mem_c2_busy", o3[1], 1'b1);
    lit("mem_c2_exmem_we", o3[5], 1'b0);
    cyc(0, 0, 0, 1, 0, 0);
    lit("mem_c3_pc_we", o3[8], 1'b1);
    lit("mem_c3_busy", o3[1], 1'b0);
    cyc(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      cyc(0, 0, 0, 1, 0, 0);
      lit("mem_b2b_pc_we", o3[8], pat[k]);
    end
    cyc(0, 0, 0, 0, 0, 0);

    // load-use alone, then with a branch
    cyc(0, 1, 0, 0, 0, 0);
    lit("lu_pc_we", o3[8], 1'b0);
    lit("lu_ifid_we", o3[7], 1'b0);
    lit("lu_id_flush", o3[2], 1'b1);
    lit("lu_idex_we", o3[6], 1'b1);
    cyc(0, 1, 1, 0, 0, 0);
    lit("lubr_pc_we", o3[8], 1'b1);
    lit("lubr_if_flush", o3[3], 1'b1);
    lit("lubr_id_flush", o3[2], 1'b1);
    cyc(0, 0, 0, 0, 0, 0);

    // branch during a latency-2 stall
    cyc(0, 0, 1, 1, 0, 0);
    lit("brmem_c1_if_flush", o2[3], 1'b0);
    lit("brmem_c1_busy", o2[1], 1'b1);
    cyc(0, 0, 1, 1, 0, 0);
    lit("brmem_c2_if_flush", o2[3], 1'b1);
    lit("brmem_c2_id_flush", o2[2], 1'b1);
    cyc(0, 0, 0, 0, 0, 0);

    // restart outside HALTED does nothing
    cyc(0, 0, 0, 0, 0, 1);
    lit("restart_run_pc_we", o3[8], 1'b1);

    // HLT drain without memory ops
    cyc(0, 0, 0, 0, 1, 0);
    lit("hlt_pc_we", o3[8], 1'b0);
    lit("hlt_id_flush", o3[2], 1'b1);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 0, 0, 0);
      lit("drain_pc_we", o3[8], 1'b0);
      lit("drain_halted", o3[0], 1'b0);
    end
    cyc(0, 0, 0, 0, 0, 0);
    lit("halted_flag", o3[0], 1'b1);
    lit("halted_idex_we", o3[6], 1'b0);
    cyc(0, 1, 1, 1, 0, 0);
    lit("halted_ignores_br", o3[3], 1'b0);
    lit("halted_no_busy", o3[1], 1'b0);
    cyc(0, 0, 0, 0, 0, 1);
    lit("restart_cycle_halted", o3[0], 1'b1);
    cyc(0, 0, 0, 0, 0, 0);
    lit("resumed_pc_we", o3[8], 1'b1);
    lit("resumed_halted", o3[0], 1'b0);

    // HLT drain stretched by a latency-2 access
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0, 0);
    lit("drainmem_busy", o2[1], 1'b1);
    lit("drainmem_idex_we", o2[6], 1'b0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    lit("drainmem_d4_halted", o2[0], 1'b0);
    cyc(0, 0, 0, 0, 0, 0);
    lit("drainmem_d5_halted", o2[0], 1'b1);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // reset during DRAIN abandons the drain
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 0, 0, 0, 0);
      lit("rst_drain_halted", o3[0], 1'b0);
      lit("rst_drain_pc_we", o3[8], 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
